// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-port ALU arbiter: default widths,
// opcode values and the control FSM state encoding.
package alu_arbiter_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int OP_WIDTH_DEF   = 4;

  // Opcodes, compared against the zero-extended opcode field
  localparam logic [31:0] OP_ADD = 32'd0;
  localparam logic [31:0] OP_SUB = 32'd1;
  localparam logic [31:0] OP_AND = 32'd2;
  localparam logic [31:0] OP_OR  = 32'd3;
  localparam logic [31:0] OP_XOR = 32'd4;
  localparam logic [31:0] OP_SLL = 32'd5;
  localparam logic [31:0] OP_SRL = 32'd6;
  localparam logic [31:0] OP_LUI = 32'd7;
  localparam logic [31:0] OP_BEQ = 32'd8;
  localparam logic [31:0] OP_BNE = 32'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU shared by both requesters. Unknown opcodes yield a
// zero result with err set.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int OP_WIDTH   = OP_WIDTH_DEF
) (
  input  logic        [OP_WIDTH-1:0]   op,
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  output logic signed [DATA_WIDTH-1:0] result,
  output logic                         err
);

  localparam int SHW = $clog2(DATA_WIDTH);

  logic [31:0]           op_ext;
  logic [SHW-1:0]        shamt;
  logic [DATA_WIDTH-1:0] a_u;

  // Decode the opcode and compute the result; shifts are logical
  always_comb begin
    op_ext = 32'(op);
    shamt  = b[SHW-1:0];
    a_u    = a;
    result = '0;
    err    = 1'b0;
    case (op_ext)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SLL:  result = a << shamt;
      OP_SRL:  result = $signed(a_u >> shamt);
      OP_LUI:  result = b << 12;
      OP_BEQ:  result = {{(DATA_WIDTH-1){1'b0}}, (a != b)};
      OP_BNE:  result = {{(DATA_WIDTH-1){1'b0}}, (a == b)};
      default: err    = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-port front end for a single shared ALU. One request is accepted in
// IDLE (round-robin when both ports ask), operands are latched, the result
// is registered at the end of EXEC and held in RESP until the granted port
// takes it.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int OP_WIDTH   = OP_WIDTH_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         p0_valid_i,
  input  logic        [OP_WIDTH-1:0]   p0_op_i,
  input  logic signed [DATA_WIDTH-1:0] p0_a_i,
  input  logic signed [DATA_WIDTH-1:0] p0_b_i,
  output logic                         p0_ready_o,
  output logic                         p0_resp_valid_o,
  input  logic                         p0_resp_ready_i,
  input  logic                         p1_valid_i,
  input  logic        [OP_WIDTH-1:0]   p1_op_i,
  input  logic signed [DATA_WIDTH-1:0] p1_a_i,
  input  logic signed [DATA_WIDTH-1:0] p1_b_i,
  output logic                         p1_ready_o,
  output logic                         p1_resp_valid_o,
  input  logic                         p1_resp_ready_i,
  output logic signed [DATA_WIDTH-1:0] result_o,
  output logic                         zero_o,
  output logic                         err_o
);

  state_t                      state;
  logic                        ptr;
  logic                        gnt;
  logic                        sel;
  logic                        accept;
  logic                        resp_done;
  logic        [OP_WIDTH-1:0]  op_q;
  logic signed [DATA_WIDTH-1:0] a_q;
  logic signed [DATA_WIDTH-1:0] b_q;
  logic signed [DATA_WIDTH-1:0] alu_result;
  logic                        alu_err;

  // Pick the port to grant: the pointer only matters when both ask
  always_comb begin
    sel       = (p0_valid_i & p1_valid_i) ? ptr : p1_valid_i;
    accept    = (state == ST_IDLE) & (p0_valid_i | p1_valid_i);
    resp_done = (state == ST_RESP) & (gnt ? p1_resp_ready_i : p0_resp_ready_i);
  end

  assign p0_ready_o      = accept & ~sel;
  assign p1_ready_o      = accept & sel;
  assign p0_resp_valid_o = (state == ST_RESP) & ~gnt;
  assign p1_resp_valid_o = (state == ST_RESP) & gnt;

  // Capture the granted port's operands; the ALU only ever sees these
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q <= sel ? p1_op_i : p0_op_i;
      a_q  <= sel ? p1_a_i  : p0_a_i;
      b_q  <= sel ? p1_b_i  : p0_b_i;
    end
  end

  alu_arbiter_alu #(
    .DATA_WIDTH (DATA_WIDTH),
    .OP_WIDTH   (OP_WIDTH)
  ) u_alu (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .result (alu_result),
    .err    (alu_err)
  );

  // Control FSM with registered result/flags; reset drops any in-flight op
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      ptr      <= 1'b0;
      gnt      <= 1'b0;
      result_o <= '0;
      zero_o   <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            gnt   <= sel;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          result_o <= alu_result;
          zero_o   <= (alu_result == '0);
          err_o    <= alu_err;
          state    <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_done) begin
            ptr   <= ~gnt;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: expected responses are queued when a
// grant is observed and compared when the response appears.
module tb_alu_arbiter;

  localparam int DW = 32;
  localparam int OW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          p0_valid_i, p1_valid_i;
  logic [OW-1:0] p0_op_i, p1_op_i;
  logic [DW-1:0] p0_a_i, p0_b_i, p1_a_i, p1_b_i;
  logic          p0_ready_o, p1_ready_o;
  logic          p0_resp_valid_o, p1_resp_valid_o;
  logic          p0_resp_ready_i, p1_resp_ready_i;
  logic [DW-1:0] result_o;
  logic          zero_o, err_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit            port;
    logic [DW-1:0] res;
    bit            zero;
    bit            err;
  } exp_t;

  exp_t exp_q[$];

  alu_arbiter #(.DATA_WIDTH(DW), .OP_WIDTH(OW)) dut (
    .clk             (clk),
    .reset           (reset),
    .p0_valid_i      (p0_valid_i),
    .p0_op_i         (p0_op_i),
    .p0_a_i          (p0_a_i),
    .p0_b_i          (p0_b_i),
    .p0_ready_o      (p0_ready_o),
    .p0_resp_valid_o (p0_resp_valid_o),
    .p0_resp_ready_i (p0_resp_ready_i),
    .p1_valid_i      (p1_valid_i),
    .p1_op_i         (p1_op_i),
    .p1_a_i          (p1_a_i),
    .p1_b_i          (p1_b_i),
    .p1_ready_o      (p1_ready_o),
    .p1_resp_valid_o (p1_resp_valid_o),
    .p1_resp_ready_i (p1_resp_ready_i),
    .result_o        (result_o),
    .zero_o          (zero_o),
    .err_o           (err_o)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input bit port, input logic [3:0] op,
                                 input logic [DW-1:0] a, input logic [DW-1:0] b);
    exp_t e;
    e.port = port;
    e.err  = 1'b0;
    case (op)
      4'd0: e.res = a + b;
      4'd1: e.res = a - b;
      4'd2: e.res = a & b;
      4'd3: e.res = a | b;
      4'd4: e.res = a ^ b;
      4'd5: e.res = a << b[4:0];
      4'd6: e.res = a >> b[4:0];
      4'd7: e.res = b << 12;
      4'd8: e.res = (a == b) ? 32'd0 : 32'd1;
      4'd9: e.res = (a != b) ? 32'd0 : 32'd1;
      default: begin
        e.res = '0;
        e.err = 1'b1;
      end
    endcase
    e.zero = (e.res == '0);
    return e;
  endfunction

  task automatic drive(input bit port, input logic [3:0] op,
                       input logic [DW-1:0] a, input logic [DW-1:0] b);
    if (port) begin
      p1_valid_i = 1'b1; p1_op_i = op; p1_a_i = a; p1_b_i = b;
    end else begin
      p0_valid_i = 1'b1; p0_op_i = op; p0_a_i = a; p0_b_i = b;
    end
  endtask

  // Withdraw a request and scramble its operands
  task automatic drop(input bit port);
    if (port) begin
      p1_valid_i = 1'b0; p1_op_i = 4'($urandom); p1_a_i = $urandom; p1_b_i = $urandom;
    end else begin
      p0_valid_i = 1'b0; p0_op_i = 4'($urandom); p0_a_i = $urandom; p0_b_i = $urandom;
    end
  endtask

  // Wait (bounded) for a grant and queue the expected response
  task automatic wait_grant(output bit port);
    int n = 0;
    #1;
    while (!(p0_ready_o | p1_ready_o) && n < 8) begin
      @(negedge clk); #1;
      n++;
    end
    port = p1_ready_o;
    check_val("grant_seen", 64'(p0_ready_o | p1_ready_o), 64'd1);
    if (p0_ready_o | p1_ready_o) begin
      check_val("ready_onehot", 64'(p0_ready_o & p1_ready_o), 64'd0);
      if (port) exp_q.push_back(model(1'b1, p1_op_i, p1_a_i, p1_b_i));
      else      exp_q.push_back(model(1'b0, p0_op_i, p0_a_i, p0_b_i));
    end
  endtask

  // Follow one granted transaction from EXEC through the response handshake
  task automatic serve(input bit port, input int stall, input bit poke_other, input bit drop_req);
    exp_t e;
    @(negedge clk); #1;
    if (drop_req) drop(port);
    check_val("exec_ready", {62'd0, p1_ready_o, p0_ready_o}, 64'd0);
    check_val("exec_resp_valid", {62'd0, p1_resp_valid_o, p0_resp_valid_o}, 64'd0);
    @(negedge clk); #1;
    check_val("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    check_val("resp_valid", {62'd0, p1_resp_valid_o, p0_resp_valid_o}, e.port ? 64'd2 : 64'd1);
    check_val("result", 64'(result_o), 64'(e.res));
    check_val("zero", 64'(zero_o), 64'(e.zero));
    check_val("err", 64'(err_o), 64'(e.err));
    for (int i = 0; i < stall; i++) begin
      if (e.port) p0_resp_ready_i = poke_other; else p1_resp_ready_i = poke_other;
      @(negedge clk); #1;
      check_val("hold_resp_valid", {62'd0, p1_resp_valid_o, p0_resp_valid_o}, e.port ? 64'd2 : 64'd1);
      check_val("hold_result", 64'(result_o), 64'(e.res));
      check_val("hold_ready", {62'd0, p1_ready_o, p0_ready_o}, 64'd0);
    end
    p0_resp_ready_i = ~e.port;
    p1_resp_ready_i = e.port;
    @(negedge clk);
    p0_resp_ready_i = 1'b0;
    p1_resp_ready_i = 1'b0;
    #1;
    check_val("idle_resp_valid", {62'd0, p1_resp_valid_o, p0_resp_valid_o}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    bit g;
    reset = 1'b0;
    p0_valid_i = 0; p1_valid_i = 0; p0_op_i = 0; p1_op_i = 0;
    p0_a_i = 0; p0_b_i = 0; p1_a_i = 0; p1_b_i = 0;
    p0_resp_ready_i = 0; p1_resp_ready_i = 0;
    repeat (2) @(negedge clk);
    #1;
    check_val("rst_result", 64'(result_o), 64'd0);
    check_val("rst_flags", {62'd0, zero_o, err_o}, 64'd0);
    check_val("rst_resp_valid", {62'd0, p1_resp_valid_o, p0_resp_valid_o}, 64'd0);
    reset = 1'b1;

    // Both ports at once right after reset: p0 first, then p1
    drive(1'b0, 4'd1, 32'd9, 32'd9);
    drive(1'b1, 4'd3, 32'hF0, 32'h0F);
    wait_grant(g);
    check_val("rr_first_p0", 64'(g), 64'd0);
    serve(g, 0, 1'b0, 1'b1);
    wait_grant(g);
    check_val("rr_second_p1", 64'(g), 64'd1);
    serve(g, 0, 1'b0, 1'b1);

    // Basic add with latency checks
    drive(1'b0, 4'd0, 32'd5, 32'd7);
    wait_grant(g);
    check_val("add_grant_p0", 64'(g), 64'd0);
    serve(g, 0, 1'b0, 1'b1);

    // Valid pulse that disappears before any clock edge
    @(negedge clk); #1;
    p1_valid_i = 1'b1;
    #2;
    p1_valid_i = 1'b0;
    @(negedge clk); #1;
    check_val("glitch_resp_valid", {62'd0, p1_resp_valid_o, p0_resp_valid_o}, 64'd0);
    @(negedge clk); #1;
    check_val("glitch_still_idle", {62'd0, p1_resp_valid_o, p0_resp_valid_o}, 64'd0);

    // Stalled response on p1 with the other port's ready pulsed
    drive(1'b1, 4'd4, 32'd3, 32'd1);
    wait_grant(g);
    check_val("xor_grant_p1", 64'(g), 64'd1);
    serve(g, 3, 1'b1, 1'b1);

    // Illegal opcode and LUI
    drive(1'b0, 4'hF, 32'd123, 32'd456);
    wait_grant(g);
    serve(g, 0, 1'b0, 1'b1);
    drive(1'b0, 4'd7, 32'd0, 32'd1);
    wait_grant(g);
    serve(g, 1, 1'b0, 1'b1);

    // Random single-port traffic across all opcodes
    for (int i = 0; i < 10; i++) begin
      drive(1'($urandom), 4'($urandom_range(0, 11)), $urandom,
            (i % 3 == 0) ? 32'($urandom_range(0, 31)) : $urandom);
      wait_grant(g);
      serve(g, $urandom_range(0, 2), 1'b1, 1'b1);
    end

    // Reset during EXEC discards the operation
    drive(1'b0, 4'd0, 32'd1, 32'd1);
    wait_grant(g);
    @(negedge clk); #1;
    reset = 1'b0;
    drop(1'b0);
    #1;
    exp_q.delete();
    check_val("rst_exec_result", 64'(result_o), 64'd0);
    check_val("rst_exec_flags", {62'd0, zero_o, err_o}, 64'd0);
    check_val("rst_exec_resp_valid", {62'd0, p1_resp_valid_o, p0_resp_valid_o}, 64'd0);
    @(negedge clk); #1;
    check_val("rst_hold_resp_valid", {62'd0, p1_resp_valid_o, p0_resp_valid_o}, 64'd0);
    reset = 1'b1;
    drive(1'b1, 4'd0, 32'd2, 32'd3);
    #1;
    check_val("post_rst_ready", 64'(p1_ready_o), 64'd1);
    wait_grant(g);
    check_val("post_rst_grant_p1", 64'(g), 64'd1);
    serve(g, 0, 1'b0, 1'b1);

    // Both held valid: grants must alternate starting from p0
    drive(1'b0, 4'd0, 32'h1234, 32'h1111);
    drive(1'b1, 4'd1, 32'h5000, 32'h0001);
    for (int i = 0; i < 6; i++) begin
      wait_grant(g);
      check_val("rr_alternate", 64'(g), 64'(i % 2));
      serve(g, i % 2, 1'b0, 1'b0);
    end
    drop(1'b0);
    drop(1'b1);
    repeat (2) @(negedge clk);
    #1;
    check_val("end_resp_valid", {62'd0, p1_resp_valid_o, p0_resp_valid_o}, 64'd0);
    check_val("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, operand/result width.
REQ-002 The block SHALL have parameter OP_WIDTH, default 4, ALU operation code width.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, with these ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- p0_valid_i / p1_valid_i  in  1  request present on port 0 / port 1
- p0_op_i / p1_op_i  in  OP_WIDTH  ALU operation code
- p0_a_i / p1_a_i  in  DATA_WIDTH  signed operand A
- p0_b_i / p1_b_i  in  DATA_WIDTH  signed operand B
- p0_ready_o / p1_ready_o  out  1  request accepted this cycle
- p0_resp_valid_o / p1_resp_valid_o  out  1  response held for that port
- p0_resp_ready_i / p1_resp_ready_i  in  1  port consumes response
- result_o  out  DATA_WIDTH  registered ALU result
- zero_o  out  1  registered result-equals-zero flag
- err_o  out  1  registered illegal-opcode flag

Function
REQ-004 The block SHALL share one ALU instance between two requesters through the FSM states IDLE, EXEC and RESP.
REQ-005 In IDLE with at least one valid request, the block SHALL accept exactly one request, assert that port's ready_o combinationally in the same cycle, latch op/a/b, and go to EXEC.
REQ-006 When both ports are valid in IDLE, the block SHALL grant the port named by a 1-bit round-robin pointer; with one port valid, it SHALL grant that port regardless of the pointer.
REQ-007 The pointer SHALL move to the port not served when a response completes.
REQ-008 ready_o SHALL be 0 in EXEC and RESP and for the non-granted port.
REQ-009 In EXEC the ALU SHALL see only the latched operands; result_o, zero_o and err_o SHALL load at the end of EXEC; the FSM then SHALL go to RESP.
REQ-010 In RESP, resp_valid_o of the granted port SHALL be 1 and result_o/zero_o/err_o SHALL stay stable until that port's resp_ready_i is 1; the block SHALL then return to IDLE.
REQ-011 Latency SHALL be: request accepted in cycle N, resp_valid_o high from cycle N+2; minimum issue interval 3 cycles.
REQ-012 Opcodes: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 5, SRL 6, LUI 7, BEQ 8, BNE 9.
REQ-013 Arithmetic SHALL wrap modulo 2^DATA_WIDTH; SLL/SRL SHALL be logical; LUI SHALL produce B<<12; BEQ/BNE SHALL produce 0 when the condition holds and 1 otherwise.
REQ-014 An opcode above 9 SHALL give result_o=0, zero_o=1 and err_o=1, with a normal handshake.
REQ-015 resp_ready_i on the non-granted port SHALL be ignored.
REQ-016 Dropping valid_i in IDLE before acceptance SHALL have no effect.
REQ-017 Operand changes after acceptance SHALL NOT affect the result.

Reset
REQ-018 Asserting reset SHALL asynchronously force IDLE, pointer=port 0, all ready/resp_valid=0, result_o=0, zero_o=0, err_o=0.
REQ-019 Reset in EXEC or RESP SHALL discard the in-flight operation with no response.
REQ-020 The first cycle after deassertion SHALL accept requests normally.

Structure
REQ-021 The opcode localparams, the FSM state encoding and DATA_WIDTH/OP_WIDTH defaults SHALL live in a shared package, also used by the control unit.
REQ-022 The block SHALL contain one sub-module, the existing ALU, instantiated once; arbitration and FSM SHALL be in alu_arbiter.

Verification
REQ-023 p0 ADD a=5 b=7 at cycle N -> p0_ready_o=1 at N, p0_resp_valid_o=1 at N+2, result_o=12, zero_o=0, err_o=0.
REQ-024 After reset, p0 and p1 valid together (p0 SUB 9,9; p1 OR 0xF0,0x0F) -> p0 served first (result 0, zero 1), then p1 (result 0xFF).
REQ-025 p1 XOR 3,1 with p1_resp_ready_i low 3 cycles -> result_o=2 held stable 4 cycles; p0_resp_ready_i pulses ignored.
REQ-026 Reset asserted during EXEC of p0 ADD 1,1 -> no resp_valid, outputs 0; next p1 request completes normally.
REQ-027 p0 op=4'b1111 -> result_o=0, zero_o=1, err_o=1; p0 LUI b=1 -> result_o=0x1000.
REQ-028 Both ports held valid for 6 transactions -> grants alternate p0,p1,p0,p1,p0,p1.
